// File: rtl/cpu_loader.sv
// Serial boot/monitor: loads program RAM from UART bytes, starts/stops the cpu,
// and reports status and halt events back over the UART transmitter.
module cpu_loader #(
  parameter int unsigned addr_width = 9,
  parameter int unsigned TIMEOUT    = 1200000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [addr_width-1:0] mem_waddr,
  output logic [7:0]            mem_data_in,
  output logic                  mem_write,
  output logic                  mem_owner,
  output logic                  cpu_reset,
  output logic [addr_width-1:0] start_address,
  input  logic                  cpu_halted
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, AHI, ALO, NHI, NLO, DATA, RESP} state_t;

  state_t                state, nxt_state;
  logic                  cmd_go, nxt_cmd_go;
  logic [15:0]           addr, nxt_addr;
  logic [15:0]           count, nxt_count;
  logic [TW-1:0]         timer, nxt_timer;
  logic                  running, nxt_running;
  logic                  halt_pending, nxt_halt_pending;
  logic                  halted_q;
  logic [addr_width-1:0] nxt_waddr, nxt_start;
  logic [7:0]            nxt_wdata, nxt_tx_data;
  logic                  nxt_write, nxt_tx_valid, nxt_cpu_reset;
  logic                  reply;
  logic [7:0]            reply_byte;
  logic [15:0]           rx_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cmd_go        <= 1'b0;
      addr          <= '0;
      count         <= '0;
      timer         <= '0;
      running       <= 1'b0;
      halt_pending  <= 1'b0;
      halted_q      <= 1'b0;
      mem_waddr     <= '0;
      mem_data_in   <= '0;
      mem_write     <= 1'b0;
      tx_data       <= '0;
      tx_valid      <= 1'b0;
      cpu_reset     <= 1'b1;
      mem_owner     <= 1'b1;
      start_address <= '0;
    end else begin
      state         <= nxt_state;
      cmd_go        <= nxt_cmd_go;
      addr          <= nxt_addr;
      count         <= nxt_count;
      timer         <= nxt_timer;
      running       <= nxt_running;
      halt_pending  <= nxt_halt_pending;
      halted_q      <= cpu_halted;
      mem_waddr     <= nxt_waddr;
      mem_data_in   <= nxt_wdata;
      mem_write     <= nxt_write;
      tx_data       <= nxt_tx_data;
      tx_valid      <= nxt_tx_valid;
      cpu_reset     <= nxt_cpu_reset;
      mem_owner     <= nxt_cpu_reset;
      start_address <= nxt_start;
    end
  end

  always_comb begin
    nxt_state        = state;
    nxt_cmd_go       = cmd_go;
    nxt_addr         = addr;
    nxt_count        = count;
    nxt_timer        = '0;
    nxt_running      = running;
    nxt_halt_pending = halt_pending;
    nxt_waddr        = mem_waddr;
    nxt_wdata        = mem_data_in;
    nxt_write        = 1'b0;
    nxt_tx_data      = tx_data;
    nxt_tx_valid     = tx_valid;
    nxt_cpu_reset    = cpu_reset;
    nxt_start        = start_address;
    reply            = 1'b0;
    reply_byte       = 8'h00;
    rx_count         = {count[15:8], rx_data};

    // Address advances in the cycle after each write pulse
    if (mem_write) nxt_waddr = mem_waddr + addr_width'(1);

    if (cpu_halted && !halted_q && running) begin
      nxt_halt_pending = 1'b1;
      nxt_running      = 1'b0;
    end

    case (state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            8'h4C: begin
              nxt_cpu_reset = 1'b1;
              nxt_running   = 1'b0;
              nxt_cmd_go    = 1'b0;
              nxt_state     = AHI;
            end
            8'h47: begin
              nxt_cmd_go = 1'b1;
              nxt_state  = AHI;
            end
            8'h52: begin
              nxt_cpu_reset = 1'b1;
              nxt_running   = 1'b0;
              reply         = 1'b1;
              reply_byte    = 8'h4B;
            end
            8'h53: begin
              reply      = 1'b1;
              reply_byte = {6'b0, cpu_halted, running};
            end
            default: begin
              reply      = 1'b1;
              reply_byte = 8'h3F;
            end
          endcase
        end else if (halt_pending) begin
          nxt_halt_pending = 1'b0;
          reply            = 1'b1;
          reply_byte       = 8'h48;
        end
      end
      AHI, ALO, NHI, NLO, DATA: begin
        if (rx_valid) begin
          case (state)
            AHI: begin
              nxt_addr[15:8] = rx_data;
              nxt_state      = ALO;
            end
            ALO: begin
              nxt_addr[7:0] = rx_data;
              if (cmd_go) begin
                nxt_start     = addr_width'({addr[15:8], rx_data});
                nxt_cpu_reset = 1'b0;
                nxt_running   = 1'b1;
                reply         = 1'b1;
                reply_byte    = 8'h4B;
              end else begin
                nxt_state = NHI;
              end
            end
            NHI: begin
              nxt_count[15:8] = rx_data;
              nxt_state       = NLO;
            end
            NLO: begin
              if (rx_count == 16'd0) begin
                reply      = 1'b1;
                reply_byte = 8'h4B;
              end else begin
                nxt_count = rx_count;
                nxt_waddr = addr_width'(addr);
                nxt_state = DATA;
              end
            end
            default: begin
              nxt_wdata = rx_data;
              nxt_write = 1'b1;
              nxt_count = count - 16'd1;
              if (count == 16'd1) begin
                reply      = 1'b1;
                reply_byte = 8'h4B;
              end
            end
          endcase
        end else if (timer == TW'(TIMEOUT - 1)) begin
          reply      = 1'b1;
          reply_byte = 8'h54;
        end else begin
          nxt_timer = timer + TW'(1);
        end
      end
      default: begin
        // RESP: tx_valid is held until the transmitter takes the byte
        if (tx_ready) begin
          nxt_tx_valid = 1'b0;
          nxt_state    = IDLE;
        end
      end
    endcase

    if (reply) begin
      nxt_tx_data  = reply_byte;
      nxt_tx_valid = 1'b1;
      nxt_state    = RESP;
      nxt_timer    = '0;
    end
  end

endmodule

// File: tb/tb_cpu_loader.sv
// Directed bench for cpu_loader: command table plus hand sequences for
// go/halt, timeout, backpressure and asynchronous reset mid-load.
module tb_cpu_loader;

  localparam int unsigned AW = 9;
  localparam int unsigned TO = 50;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_data_in;
  logic          mem_write;
  logic          mem_owner;
  logic          cpu_reset;
  logic [AW-1:0] start_address;
  logic          cpu_halted = 1'b0;

  cpu_loader #(.addr_width(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_waddr(mem_waddr), .mem_data_in(mem_data_in), .mem_write(mem_write),
    .mem_owner(mem_owner), .cpu_reset(cpu_reset),
    .start_address(start_address), .cpu_halted(cpu_halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  // rx/wa/wd are right-justified; first item sits in the most significant slot
  typedef struct packed {
    logic [63:0] rx;
    logic [3:0]  n;
    logic [7:0]  reply;
    logic [1:0]  nwr;
    logic [26:0] wa;
    logic [23:0] wd;
  } vec_t;

  wr_t wq[$];
  int  bad_wr = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  always @(negedge clk) begin
    if (mem_write) begin
      wq.push_back({mem_waddr, mem_data_in});
      if (!cpu_reset) bad_wr++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input string name);
    int cnt = 0;
    while (!tx_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check({name, "_valid"}, 32'(tx_valid), 32'd1);
  endtask

  task automatic expect_reply(input string name, input logic [7:0] exp);
    wait_tx(name);
    check(name, 32'(tx_data), 32'(exp));
    if (tx_valid) begin
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      check({name, "_drop"}, 32'(tx_valid), 32'd0);
    end
  endtask

  vec_t vecs[6];
  vec_t v;
  int   cnt;

  initial begin
    vecs[0] = '{64'h4C00100003AABBCC, 4'd8, 8'h4B, 2'd3,
                {9'h010, 9'h011, 9'h012}, {8'hAA, 8'hBB, 8'hCC}};
    vecs[1] = '{64'h00004C01FF000211, 4'd7, 8'h4B, 2'd2,
                27'({9'h1FF, 9'h000}), 24'({8'h11, 8'h22})};
    vecs[1].rx = 64'h004C01FF00021122;
    vecs[2] = '{64'h0000004C00000000, 4'd5, 8'h4B, 2'd0, 27'd0, 24'd0};
    vecs[3] = '{64'h99, 4'd1, 8'h3F, 2'd0, 27'd0, 24'd0};
    vecs[4] = '{64'h53, 4'd1, 8'h00, 2'd0, 27'd0, 24'd0};
    vecs[5] = '{64'h52, 4'd1, 8'h4B, 2'd0, 27'd0, 24'd0};

    repeat (2) @(negedge clk);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_mem_owner", 32'(mem_owner), 32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_start_address", 32'(start_address), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      wq.delete();
      for (int k = 0; k < int'(v.n); k++)
        send_byte(v.rx[8*(int'(v.n)-1-k) +: 8]);
      expect_reply($sformatf("v%0d_reply", i), v.reply);
      check($sformatf("v%0d_cpu_reset", i), 32'(cpu_reset), 32'd1);
      check($sformatf("v%0d_nwr", i), 32'(wq.size()), 32'(v.nwr));
      for (int j = 0; j < int'(v.nwr); j++) begin
        if (j < wq.size()) begin
          check($sformatf("v%0d_waddr%0d", i, j), 32'(wq[j].a),
                32'(v.wa[9*(int'(v.nwr)-1-j) +: 9]));
          check($sformatf("v%0d_wdata%0d", i, j), 32'(wq[j].d),
                32'(v.wd[8*(int'(v.nwr)-1-j) +: 8]));
        end
      end
    end

    // Go, status while running, halt notification, status after halt
    send_byte(8'h47); send_byte(8'h00); send_byte(8'h20);
    expect_reply("go_reply", 8'h4B);
    check("go_start_address", 32'(start_address), 32'h020);
    check("go_cpu_reset", 32'(cpu_reset), 32'd0);
    check("go_mem_owner", 32'(mem_owner), 32'd0);
    send_byte(8'h53);
    expect_reply("status_running", 8'h01);
    @(negedge clk);
    cpu_halted = 1'b1;
    expect_reply("halt_reply", 8'h48);
    check("halt_cpu_reset", 32'(cpu_reset), 32'd0);
    send_byte(8'h53);
    expect_reply("status_halted", 8'h02);
    cpu_halted = 1'b0;

    // Inter-byte timeout while waiting for the count
    wq.delete();
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!tx_valid && cnt < 200);
    check("timeout_cycles", 32'(cnt), 32'(TO));
    expect_reply("timeout_reply", 8'h54);
    check("timeout_nwr", 32'(wq.size()), 32'd0);
    check("timeout_cpu_reset", 32'(cpu_reset), 32'd1);
    send_byte(8'h53);
    expect_reply("timeout_status", 8'h00);

    // Unknown byte under backpressure; later rx bytes must be dropped
    send_byte(8'h99);
    wait_tx("bp");
    send_byte(8'h4C);
    send_byte(8'h53);
    repeat (3) @(negedge clk);
    check("bp_held_valid", 32'(tx_valid), 32'd1);
    check("bp_held_data", 32'(tx_data), 32'h3F);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("bp_accept_drop", 32'(tx_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_single_accept", 32'(tx_valid), 32'd0);
    send_byte(8'h53);
    expect_reply("bp_status", 8'h00);

    // Asynchronous reset in the middle of a data phase
    send_byte(8'h47); send_byte(8'h01); send_byte(8'h23);
    expect_reply("go2_reply", 8'h4B);
    check("go2_start_address", 32'(start_address), 32'h123);
    wq.delete();
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h30);
    send_byte(8'h00); send_byte(8'h05);
    send_byte(8'hAA); send_byte(8'hBB);
    repeat (2) @(negedge clk);
    check("mid_nwr", 32'(wq.size()), 32'd2);
    check("mid_waddr", 32'(mem_waddr), 32'h032);
    #2 reset = 1'b1;
    #1;
    check("arst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("arst_mem_owner", 32'(mem_owner), 32'd1);
    check("arst_start_address", 32'(start_address), 32'd0);
    check("arst_mem_waddr", 32'(mem_waddr), 32'd0);
    check("arst_mem_data_in", 32'(mem_data_in), 32'd0);
    check("arst_mem_write", 32'(mem_write), 32'd0);
    check("arst_tx_valid", 32'(tx_valid), 32'd0);
    check("arst_tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h53);
    expect_reply("post_reset_status", 8'h00);

    check("write_while_running", 32'(bad_wr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_loader.md
Name: cpu_loader

Overview:
- Serial boot/monitor block upstream of the cpu core; it fills program memory and controls the cpu.
- Consumes bytes from the UART receiver and writes them into the shared byte-wide program RAM through the RAM write port.
- Drives the cpu's reset and start_address inputs and reports halt events back over the UART transmitter.
- Owns the RAM write port whenever it holds the cpu in reset (mem_owner=1); the top level muxes on mem_owner.

Parameters:
- addr_width, 9, width of RAM addresses; must match the cpu.
- TIMEOUT, 1200000, inter-byte timeout in clk cycles (100 ms at 12 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data valid
- tx_data  out  8  byte to transmit
- tx_valid  out  1  transmit request; held until accepted
- tx_ready  in  1  transmitter accepts tx_data when tx_valid&tx_ready
- mem_waddr  out  addr_width  RAM write address
- mem_data_in  out  8  RAM write data
- mem_write  out  1  RAM write strobe, one cycle per byte
- mem_owner  out  1  1 = loader owns RAM write port (equals cpu_reset)
- cpu_reset  out  1  reset to cpu
- start_address  out  addr_width  cpu start address
- cpu_halted  in  1  cpu halted flag

Behaviour:
- Reset values (async): cpu_reset=1, mem_owner=1, start_address=0, mem_waddr=0, mem_data_in=0, mem_write=0, tx_data=0, tx_valid=0, running=0, halt_pending=0, timer=0, state=IDLE.
- Command protocol (all multi-byte fields big-endian, 16-bit; addresses truncated to addr_width bits):
  - 'L'(0x4C) AH AL NH NL then N data bytes: load.
  - 'G'(0x47) AH AL: go.
  - 'R'(0x52): stop.
  - 'S'(0x53): status.
  - Any other byte in IDLE -> reply '?'(0x3F).
- States: IDLE, AHI, ALO, NHI, NLO, DATA, RESP.
- IDLE:
  - On rx_valid with 'L': set cpu_reset=1, running=0, go to AHI.
  - On 'G': go to AHI with cmd=G.
  - On 'R': set cpu_reset=1, running=0, reply 'K'(0x4B).
  - On 'S': reply {6'b0, cpu_halted, running}.
- AHI/ALO: latch address bytes. For G, after ALO load start_address, go to RESP with 'K'; cpu_reset is deasserted in the cycle RESP is entered, and running=1.
- NHI/NLO: latch the 16-bit count.
  - If count=0: RESP 'K' directly, no writes.
  - Otherwise go to DATA, with mem_waddr=address.
- DATA: each rx_valid produces mem_data_in=rx_data and mem_write=1 in the following cycle, at the current mem_waddr.
  - mem_waddr increments after each write and wraps modulo 2^addr_width.
  - Count decrements; when it reaches 0, go to RESP 'K'.
- RESP: tx_valid=1 with tx_data; on tx_valid&tx_ready, drop tx_valid and return to IDLE. rx bytes arriving in RESP are discarded.
- Timeout:
  - timer resets on every rx_valid and counts only in AHI..DATA.
  - When timer reaches TIMEOUT-1: abort to RESP with 'T'(0x54). Bytes already written stay written; cpu_reset stays 1.
- Halt notification:
  - A rising edge of cpu_halted while running=1 sets halt_pending and clears running; cpu_reset stays 0 so the cpu stays halted.
  - In IDLE with halt_pending: send 'H'(0x48) via RESP, clear halt_pending.
  - An rx command arriving in the same cycle takes precedence; 'H' is sent after that command's reply.
- mem_write is never asserted while cpu_reset=0.
- Async reset mid-transfer: immediate return to reset values; a partially loaded image is not erased.

Test Plan:
- Load: send 4C 00 10 00 03 AA BB CC -> exactly 3 mem_write pulses at addresses 0x010, 0x011, 0x012 with data AA, BB, CC, then tx 'K'; cpu_reset=1 throughout.
- Wrap: with addr_width=9, send 4C 01 FF 00 02 11 22 -> writes 0x1FF=11 and 0x000=22, then 'K'.
- Go and halt: send 47 00 20 -> start_address=0x020, cpu_reset falls, 'K'; raise cpu_halted -> tx 'H'; then 53 -> tx 0x02.
- Timeout: send 4C 00 00, then idle TIMEOUT cycles (use TIMEOUT=50 in the bench) -> tx 'T', state IDLE, no mem_write.
- Backpressure and unknown byte: hold tx_ready=0, send 0x99 -> tx_valid=1 with 0x3F held stable, extra rx bytes ignored; release tx_ready -> single accept, back to IDLE.
- Zero length and reset: 4C 00 00 00 00 -> immediate 'K'. Assert reset during DATA -> all outputs return to reset values asynchronously.
